if_mem_bus_arbiter: RTL

Shares the single external memory bus between instruction fetch (IF, read-only, driven by the PC register's physical pc/ce) and the MEM stage (load/store). MEM has fixed priority over IF. Each requester gets a one-entry completion buffer and a stall request to the pipeline controller, so an access finished while the pipeline is frozen is neither repeated nor lost.

---
 rtl/if_mem_bus_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/if_mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and the MEM stage; MEM has fixed priority over IF.
// Optional BUS_TIMEOUT_EN macro adds an abort after TIMEOUT_CYCLES cycles without bus_ack_i.
module if_mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stallreq_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_ACC  = 2'd1,
        ST_MEM_ACC = 2'd2
    } state_e;

    state_e      state_r;
    logic        if_valid_r;
    logic        mem_valid_r;
    logic        discard_r;
    logic        bus_req_r;
    logic        bus_we_r;
    logic [3:0]  bus_sel_r;
    logic [31:0] bus_addr_r;
    logic [31:0] bus_wdata_r;
    logic [31:0] if_data_r;
    logic [31:0] mem_data_r;

    logic        if_pend_s;
    logic        mem_pend_s;
    logic        abort_s;
    logic        done_s;
    logic        take_s;
    logic [31:0] result_s;
    logic        unused_stall_s;

`ifdef BUS_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt_r;
    logic                bus_err_r;

    // Timeout fires on the last allowed request cycle; a same-cycle ack takes precedence.
    always_comb begin
        if ((state_r != ST_IDLE) && !bus_ack_i &&
            (to_cnt_r == TO_CNT_W'(TIMEOUT_CYCLES - 1))) begin
            abort_s = 1'b1;
        end else begin
            abort_s = 1'b0;
        end
    end

    assign bus_err_o = bus_err_r;
`else
    logic [TO_CNT_W-1:0] unused_to_cnt_s;

    assign unused_to_cnt_s = TO_CNT_W'(TIMEOUT_CYCLES);
    assign abort_s         = 1'b0;
    assign bus_err_o       = 1'b0;
`endif

    assign if_pend_s      = if_ce_i & ~if_valid_r;
    assign mem_pend_s     = mem_ce_i & ~mem_valid_r;
    assign if_stallreq_o  = if_pend_s;
    assign mem_stallreq_o = mem_pend_s;
    assign unused_stall_s = ^{stall[5], stall[3:2], stall[0]};

    // A flush arriving on the completing edge drops the result just like a discarded access.
    assign done_s   = (state_r != ST_IDLE) & (bus_ack_i | abort_s);
    assign take_s   = done_s & ~discard_r & ~flush;
    assign result_s = bus_ack_i ? bus_rdata_i : 32'h0000_0000;

    assign bus_req_o   = bus_req_r;
    assign bus_we_o    = bus_we_r;
    assign bus_sel_o   = bus_sel_r;
    assign bus_addr_o  = bus_addr_r;
    assign bus_wdata_o = bus_wdata_r;
    assign if_data_o   = if_data_r;
    assign mem_data_o  = mem_data_r;

    // Arbiter FSM, completion buffers and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            if_valid_r  <= 1'b0;
            mem_valid_r <= 1'b0;
            discard_r   <= 1'b0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_sel_r   <= 4'b0000;
            bus_addr_r  <= 32'h0000_0000;
            bus_wdata_r <= 32'h0000_0000;
            if_data_r   <= 32'h0000_0000;
            mem_data_r  <= 32'h0000_0000;
`ifdef BUS_TIMEOUT_EN
            to_cnt_r    <= '0;
            bus_err_r   <= 1'b0;
`endif
        end else begin
`ifdef BUS_TIMEOUT_EN
            bus_err_r <= 1'b0;
`endif
            // Later assignments below override these clears, so a same-edge set wins.
            if (stall[1] == NO_STOP) begin
                if_valid_r <= 1'b0;
            end
            if (stall[4] == NO_STOP) begin
                mem_valid_r <= 1'b0;
            end
            if (flush) begin
                if_valid_r  <= 1'b0;
                mem_valid_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    discard_r <= 1'b0;
                    if (!flush && mem_pend_s) begin
                        state_r     <= ST_MEM_ACC;
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= mem_we_i;
                        bus_sel_r   <= mem_sel_i;
                        bus_addr_r  <= mem_addr_i;
                        bus_wdata_r <= mem_data_i;
`ifdef BUS_TIMEOUT_EN
                        to_cnt_r    <= '0;
`endif
                    end else if (!flush && if_pend_s) begin
                        state_r     <= ST_IF_ACC;
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= 1'b0;
                        bus_sel_r   <= 4'b1111;
                        bus_addr_r  <= if_addr_i;
                        bus_wdata_r <= 32'h0000_0000;
`ifdef BUS_TIMEOUT_EN
                        to_cnt_r    <= '0;
`endif
                    end else begin
                        bus_req_r <= 1'b0;
                    end
                end
                ST_IF_ACC, ST_MEM_ACC: begin
                    if (done_s) begin
                        state_r   <= ST_IDLE;
                        bus_req_r <= 1'b0;
                        discard_r <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                        bus_err_r <= abort_s;
`endif
                        if (take_s && (state_r == ST_IF_ACC)) begin
                            if_data_r  <= result_s;
                            if_valid_r <= 1'b1;
                        end else if (take_s) begin
                            mem_data_r  <= result_s;
                            mem_valid_r <= 1'b1;
                        end
                    end else begin
                        // The bus cycle is never abandoned on flush; only its result is.
                        if (flush) begin
                            discard_r <= 1'b1;
                        end
`ifdef BUS_TIMEOUT_EN
                        to_cnt_r <= to_cnt_r + TO_CNT_W'(1);
`endif
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bus_req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
